// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO (write and read sides).
//   ADDR_SIZE_DEF : default RAM address width (depth = 2**ADDR_SIZE_DEF)
//   CONV_W        : width of the generic Gray/binary conversion helpers
//   bin2gray()    : binary -> reflected Gray code (zero-extend narrower values)
//   gray2bin()    : reflected Gray code -> binary (zero-extend narrower values)
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int ADDR_SIZE_DEF = 4;
    localparam int CONV_W        = 32;

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above its position.
    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
        logic [CONV_W-1:0] bin;
        bin = {CONV_W{1'b0}};
        for (int i = 0; i < CONV_W; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// -----------------------------------------------------------------------------
// fifo_gray2bin
// Purely combinational Gray-to-binary converter of parameterized width.
// Used for the synchronized read pointer here and reusable on the read side.
//   gray_i : Gray-coded input  [WIDTH-1:0]
//   bin_o  : binary equivalent [WIDTH-1:0]
// -----------------------------------------------------------------------------
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int WIDTH = ADDR_SIZE_DEF + 1
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    logic [WIDTH-1:0] bin_s;

    // Each bit is a reduction XOR of the shifted Gray word; no bit depends on
    // another output bit, so there is no combinational chain through bin_s.
    always_comb begin
        bin_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            bin_s[i] = ^(gray_i >> i);
        end
    end

    assign bin_o = bin_s;

endmodule

// File: rtl/fifo_wrt_ptr_full_gen.sv
// -----------------------------------------------------------------------------
// fifo_wrt_ptr_full_gen
// Write-side pointer and flag generator of the asynchronous FIFO, entirely in
// the write clock domain.
//   wrt_clk         : write clock
//   wrt_rst         : synchronous active-high reset
//   wrt_ena         : write request from producer
//   ovf_clr         : clears the sticky overflow flag
//   sync_rd_ptr     : Gray read pointer, already synchronized into wrt_clk
//   wrt_accept      : wrt_ena & ~wrt_full, RAM write enable (combinational)
//   wrt_addr        : RAM write address
//   wrt_ptr         : registered Gray write pointer to the read-side synchronizer
//   wrt_full        : registered full flag
//   wrt_almost_full : registered flag, fill level >= AF_THRESH
//   wrt_level       : registered fill level 0..2**ADDR_SIZE
//   wrt_overflow    : sticky flag, a write was attempted while full
// Level and flags are computed against a lagging read pointer, so they are
// pessimistic: full can deassert late but never asserts late.
// -----------------------------------------------------------------------------
module fifo_wrt_ptr_full_gen
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int AF_THRESH = 12
) (
    input  logic                 wrt_clk,
    input  logic                 wrt_rst,
    input  logic                 wrt_ena,
    input  logic                 ovf_clr,
    input  logic [ADDR_SIZE:0]   sync_rd_ptr,
    output logic                 wrt_accept,
    output logic [ADDR_SIZE-1:0] wrt_addr,
    output logic [ADDR_SIZE:0]   wrt_ptr,
    output logic                 wrt_full,
    output logic                 wrt_almost_full,
    output logic [ADDR_SIZE:0]   wrt_level,
    output logic                 wrt_overflow
);

    localparam int             PW     = ADDR_SIZE + 1;
    localparam logic [PW-1:0]  AF_LVL = PW'(AF_THRESH);

    logic [PW-1:0] wrt_bin_r;
    logic [PW-1:0] wrt_ptr_r;
    logic          wrt_full_r;
    logic          wrt_af_r;
    logic [PW-1:0] wrt_level_r;
    logic          wrt_ovf_r;

    logic          wrt_accept_s;
    logic [PW-1:0] wrt_bin_nxt_s;
    logic [PW-1:0] wrt_gray_nxt_s;
    logic [PW-1:0] rd_bin_sync_s;
    logic [PW-1:0] full_cmp_s;
    logic          full_val_s;
    logic [PW-1:0] level_nxt_s;
    logic          af_nxt_s;
    logic          ovf_set_s;
    logic          ovf_nxt_s;

    fifo_gray2bin #(
        .WIDTH (PW)
    ) u_rd_gray2bin (
        .gray_i (sync_rd_ptr),
        .bin_o  (rd_bin_sync_s)
    );

    // Next pointer, full/almost-full/level evaluation on the post-write pointer.
    always_comb begin
        wrt_accept_s   = wrt_ena & ~wrt_full_r;
        wrt_bin_nxt_s  = wrt_bin_r + {{ADDR_SIZE{1'b0}}, wrt_accept_s};
        wrt_gray_nxt_s = (wrt_bin_nxt_s >> 1) ^ wrt_bin_nxt_s;
        // Full when the write pointer is exactly one lap ahead: in Gray code
        // that means the two MSBs differ and the rest match.
        full_cmp_s     = {~sync_rd_ptr[ADDR_SIZE:ADDR_SIZE-1], sync_rd_ptr[ADDR_SIZE-2:0]};
        full_val_s     = (wrt_gray_nxt_s == full_cmp_s);
        level_nxt_s    = wrt_bin_nxt_s - rd_bin_sync_s;
        af_nxt_s       = (level_nxt_s >= AF_LVL);
    end

    // Sticky overflow: a new overflow takes priority over a clear on the same edge.
    always_comb begin
        ovf_set_s = wrt_ena & wrt_full_r;
        ovf_nxt_s = wrt_ovf_r;
        if (ovf_set_s) begin
            ovf_nxt_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = wrt_ovf_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wrt_clk) begin
        if (wrt_rst) begin
            wrt_bin_r   <= {PW{1'b0}};
            wrt_ptr_r   <= {PW{1'b0}};
            wrt_full_r  <= 1'b0;
            wrt_af_r    <= 1'b0;
            wrt_level_r <= {PW{1'b0}};
            wrt_ovf_r   <= 1'b0;
        end else begin
            wrt_bin_r   <= wrt_bin_nxt_s;
            wrt_ptr_r   <= wrt_gray_nxt_s;
            wrt_full_r  <= full_val_s;
            wrt_af_r    <= af_nxt_s;
            wrt_level_r <= level_nxt_s;
            wrt_ovf_r   <= ovf_nxt_s;
        end
    end

    assign wrt_accept      = wrt_accept_s;
    assign wrt_addr        = wrt_bin_r[ADDR_SIZE-1:0];
    assign wrt_ptr         = wrt_ptr_r;
    assign wrt_full        = wrt_full_r;
    assign wrt_almost_full = wrt_af_r;
    assign wrt_level       = wrt_level_r;
    assign wrt_overflow    = wrt_ovf_r;

endmodule

// File: tb/tb_fifo_wrt_ptr_full_gen.sv
// -----------------------------------------------------------------------------
// tb_fifo_wrt_ptr_full_gen
// Directed checks of reset, fill, overflow, drain and wrap-around, followed by
// a random phase against an occupancy model with a 2-cycle-delayed read pointer.
// -----------------------------------------------------------------------------
module tb_fifo_wrt_ptr_full_gen;

    logic       wrt_clk;
    logic       wrt_rst;
    logic       wrt_ena;
    logic       ovf_clr;
    logic [4:0] sync_rd_ptr;
    logic       wrt_accept;
    logic [3:0] wrt_addr;
    logic [4:0] wrt_ptr;
    logic       wrt_full;
    logic       wrt_almost_full;
    logic [4:0] wrt_level;
    logic       wrt_overflow;

    int n_checks = 0;
    int n_errors = 0;

    fifo_wrt_ptr_full_gen #(
        .ADDR_SIZE (4),
        .AF_THRESH (12)
    ) dut (
        .wrt_clk         (wrt_clk),
        .wrt_rst         (wrt_rst),
        .wrt_ena         (wrt_ena),
        .ovf_clr         (ovf_clr),
        .sync_rd_ptr     (sync_rd_ptr),
        .wrt_accept      (wrt_accept),
        .wrt_addr        (wrt_addr),
        .wrt_ptr         (wrt_ptr),
        .wrt_full        (wrt_full),
        .wrt_almost_full (wrt_almost_full),
        .wrt_level       (wrt_level),
        .wrt_overflow    (wrt_overflow)
    );

    initial wrt_clk = 1'b0;
    always #5 wrt_clk = ~wrt_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wrt_clk);
        #1;
    endtask

    function automatic logic [4:0] gray5(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    logic [4:0] wb_m, rd_m, d1_m, d2_m, sync_m, lvl_m;
    logic       full_m, ena_m, acc_m;
    int         rd_t;

    initial begin
        // Reset with a concurrent write request
        wrt_rst = 1'b1; wrt_ena = 1'b1; ovf_clr = 1'b0; sync_rd_ptr = 5'd0;
        tick();
        check("rst_addr",  32'(wrt_addr), 32'd0);
        check("rst_ptr",   32'(wrt_ptr), 32'd0);
        check("rst_full",  32'(wrt_full), 32'd0);
        check("rst_af",    32'(wrt_almost_full), 32'd0);
        check("rst_level", 32'(wrt_level), 32'd0);
        check("rst_ovf",   32'(wrt_overflow), 32'd0);

        // One write, then reset raised between edges has no effect until the edge
        wrt_rst = 1'b0; wrt_ena = 1'b1;
        tick();
        check("w1_addr", 32'(wrt_addr), 32'd1);
        check("w1_ptr",  32'(wrt_ptr), 32'd1);
        wrt_ena = 1'b0; wrt_rst = 1'b1;
        #2;
        check("rst_mid_addr", 32'(wrt_addr), 32'd1);
        check("rst_mid_lvl",  32'(wrt_level), 32'd1);
        tick();
        check("rst_edge_addr", 32'(wrt_addr), 32'd0);
        check("rst_edge_ptr",  32'(wrt_ptr), 32'd0);
        wrt_rst = 1'b0;

        // Fill 16 entries with the reader parked at 0
        wrt_ena = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("fill_level", 32'(wrt_level), 32'(i));
            check("fill_af",    32'(wrt_almost_full), (i >= 12) ? 32'd1 : 32'd0);
            check("fill_full",  32'(wrt_full), (i == 16) ? 32'd1 : 32'd0);
        end
        check("fill_ptr",  32'(wrt_ptr), 32'b11000);
        check("fill_addr", 32'(wrt_addr), 32'd0);

        // Overflow: write while full
        #1;
        check("ovf_accept", 32'(wrt_accept), 32'd0);
        tick();
        check("ovf_ptr",  32'(wrt_ptr), 32'b11000);
        check("ovf_set",  32'(wrt_overflow), 32'd1);
        check("ovf_lvl",  32'(wrt_level), 32'd16);
        wrt_ena = 1'b0; ovf_clr = 1'b1;
        tick();
        check("ovf_clr", 32'(wrt_overflow), 32'd0);
        wrt_ena = 1'b1; ovf_clr = 1'b1;
        tick();
        check("ovf_set_wins", 32'(wrt_overflow), 32'd1);
        wrt_ena = 1'b0; ovf_clr = 1'b0;

        // Drain: reader progress seen via synchronized Gray pointer
        sync_rd_ptr = 5'b00110;
        tick();
        check("drain4_full", 32'(wrt_full), 32'd0);
        check("drain4_lvl",  32'(wrt_level), 32'd12);
        check("drain4_af",   32'(wrt_almost_full), 32'd1);
        sync_rd_ptr = 5'b00111;
        tick();
        check("drain5_af",  32'(wrt_almost_full), 32'd0);
        check("drain5_lvl", 32'(wrt_level), 32'd11);

        // Wrap: 20 writes with the reader trailing by 3
        wrt_rst = 1'b1; sync_rd_ptr = 5'd0;
        tick();
        wrt_rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            rd_t = (i > 3) ? i - 3 : 0;
            sync_rd_ptr = gray5(5'(rd_t));
            wrt_ena = 1'b1;
            tick();
            check("wrap_lvl", 32'(wrt_level), 32'(i - rd_t));
            if (i == 15) check("wrap_addr15", 32'(wrt_addr), 32'd15);
            if (i == 16) check("wrap_addr0",  32'(wrt_addr), 32'd0);
        end
        check("wrap_ptr", 32'(wrt_ptr), 32'b11110);
        wrt_ena = 1'b0; sync_rd_ptr = 5'b11110;
        tick();
        check("wrap_lvl0",  32'(wrt_level), 32'd0);
        check("wrap_full0", 32'(wrt_full), 32'd0);

        // Random writes against an occupancy model
        wrt_rst = 1'b1; sync_rd_ptr = 5'd0; wrt_ena = 1'b0;
        tick();
        wrt_rst = 1'b0;
        wb_m = 5'd0; rd_m = 5'd0; d1_m = 5'd0; d2_m = 5'd0; full_m = 1'b0;
        for (int c = 0; c < 300; c++) begin
            ena_m = ($urandom_range(0, 3) != 0);
            if (($urandom_range(0, 2) == 0) && (rd_m != wb_m)) rd_m = rd_m + 5'd1;
            sync_m = d2_m; d2_m = d1_m; d1_m = rd_m;
            wrt_ena = ena_m;
            sync_rd_ptr = gray5(sync_m);
            #1;
            acc_m = ena_m & ~full_m;
            check("rnd_accept", 32'(wrt_accept), 32'(acc_m));
            tick();
            wb_m   = wb_m + 5'(acc_m);
            lvl_m  = wb_m - sync_m;
            full_m = (lvl_m == 5'd16);
            check("rnd_level", 32'(wrt_level), 32'(lvl_m));
            check("rnd_full",  32'(wrt_full), 32'(full_m));
            check("rnd_af",    32'(wrt_almost_full), (lvl_m >= 5'd12) ? 32'd1 : 32'd0);
            check("rnd_ptr",   32'(wrt_ptr), 32'(gray5(wb_m)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
